branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Control-unit step generator for the conditional-branch instructions (brzr, brnz, brpl, brmi). It takes over after instruction fetch, drives the datapath strobes for steps T3–T6, and raises CONin so the condition flip-flop samples R[ra]. It then reads that flip-flop's result back and either loads PC with PC+C or leaves PC unchanged. It sits in the control unit alongside the fetch sequencer and is the producer of CONin and the consumer of CON.

## Interface
Parameters:
- OPC_BR, 5'b10010, opcode value in ir[31:27] that identifies a conditional branch.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registered outputs.
- start  in  1  one-cycle request from the main control once IR holds a fetched instruction.
- hold  in  1  memory/bus stall; freezes the FSM in its current step.
- ir  in  32  current instruction register contents.
- con  in  1  Q of the condition flip-flop.
- Gra, Rout, CONin  out  1 each  select R[ra] onto the bus and strobe the condition flip-flop (T3).
- PCout, Yin  out  1 each  PC onto the bus, latch into Y (T4).
- Cout, add_sel, Zin  out  1 each  sign-extended C onto the bus, ALU ADD, latch Z (T5).
- Zlowout, PCin  out  1 each  Z[31:0] onto the bus, load PC; PCin only when taken (T6).
- c_sext  out  32  {{13{ir[18]}}, ir[18:0]}, combinational.
- busy  out  1  high in any state other than IDLE.
- done  out  1  high in the T6 cycle only.
- taken  out  1  registered branch decision; holds until the next accepted start.
- illegal  out  1  one-cycle pulse when start arrives with ir[31:27] != OPC_BR.

## Operation
- States: IDLE, T3, T4, T5, T6. Moore decode: all strobes come from the current state only.
- IDLE: all strobes 0.
  - start=1 with ir[31:27]==OPC_BR → T3.
  - start=1 with any other opcode → illegal=1 on the next cycle; stay IDLE.
- T3: Gra=Rout=CONin=1.
- T4: PCout=Yin=1. At the T3→T4 edge, taken <= con.
- T5: Cout=add_sel=Zin=1.
- T6: Zlowout=1, PCin=taken, done=1 → IDLE.
- Condition encoding belongs to the flip-flop (ir[20:19]: 00 zero, 01 nonzero, 10 positive, 11 negative). This block never decodes ir[20:19].
- hold=1 in T3–T6: the state does not advance and the current step's strobes stay asserted. Re-strobing is idempotent (same Y, Z, PC values).
  - taken is not re-captured while held in T3; capture happens only on the advancing edge.
  - hold in IDLE has no effect; a start during hold is still accepted.
- start while busy=1 is ignored and does not raise illegal.
- Reset, asynchronous at any point including mid-T4/T5: state=IDLE; taken, illegal, busy, done and all strobes = 0. PCin is never asserted in the reset cycle.

## Timing
- Latency: start accepted at edge k → T3 in cycle k+1, T6/done in cycle k+4 (no hold). Each held cycle adds exactly one cycle.
- taken is valid from the T4 cycle onward and is stable through done.
- illegal is asserted for exactly one cycle, the cycle after the rejected start.
- busy=1 in the cycles from T3 through T6 inclusive; busy=0 in the cycle after done.
- Back-to-back: a start in the cycle after T6 (IDLE) is accepted, giving a minimum 5-cycle spacing between branches.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state encoding (3-bit: IDLE=0, T3..T6=1..4);
  - opcode constants, including OPC_BR default;
  - the C-field width (19).
- No sub-module: the sign extension and the FSM are written inline. The flip-flop stays a separate block instantiated at datapath level.

## Test plan
- brzr, R[ra]=0 (con=1 in T3), PC=0x10, C=0x4 → T6: Zlowout=1, PCin=1, taken=1, done=1 at start+4.
- brnz, R[ra]=5 driven so con=0 → T6: PCin=0, taken=0, Zlowout=1, done=1; PC unchanged.
- ir[18:0]=19'h7FFFC → c_sext=32'hFFFFFFFC. ir[18:0]=19'h00003 → c_sext=32'h00000003.
- hold=1 for 3 cycles entering T5 → Cout/Zin stay high 4 cycles total, done at start+7, taken unchanged.
- Reset pulse during T4 → same cycle: all strobes 0, busy=0, taken=0. Next start restarts at T3.
- start with ir[31:27]=5'b00011 → illegal=1 for one cycle, busy stays 0. A start while busy is ignored with no illegal pulse.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: step encoding, opcode constants, C-field helpers.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_WIDTH = 5;
  localparam int unsigned C_WIDTH   = 19;
  localparam int unsigned WORD      = 32;

  typedef logic [OPC_WIDTH-1:0] opcode_t;

  // Opcode map (ir[31:27]); the branch value is the default for branch_sequencer.
  localparam opcode_t OPC_LD         = 5'b00000;
  localparam opcode_t OPC_LDI        = 5'b00001;
  localparam opcode_t OPC_ST         = 5'b00010;
  localparam opcode_t OPC_ADD        = 5'b00011;
  localparam opcode_t OPC_SUB        = 5'b00100;
  localparam opcode_t OPC_BR_DEFAULT = 5'b10010;
  localparam opcode_t OPC_JR         = 5'b10011;
  localparam opcode_t OPC_JAL        = 5'b10100;

  // Branch sequencer steps: IDLE=0, T3..T6=1..4.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_T4   = 3'd2,
    ST_T5   = 3'd3,
    ST_T6   = 3'd4
  } br_state_t;

  // Sign-extend the C field to a full datapath word.
  function automatic logic [WORD-1:0] sext_c(input logic [C_WIDTH-1:0] c);
    return {{(WORD - C_WIDTH){c[C_WIDTH-1]}}, c};
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Handshake and datapath-strobe bundle between main control and the branch sequencer.
interface branch_sequencer_if;

  // Requests and status from the rest of the control unit / datapath
  logic        start;
  logic        hold;
  logic [31:0] ir;
  logic        con;

  // Datapath strobes
  logic        Gra;
  logic        Rout;
  logic        CONin;
  logic        PCout;
  logic        Yin;
  logic        Cout;
  logic        add_sel;
  logic        Zin;
  logic        Zlowout;
  logic        PCin;

  // Data and status back to main control
  logic [31:0] c_sext;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;

  // Main control side
  modport master (
    output start, hold, ir, con,
    input  Gra, Rout, CONin, PCout, Yin, Cout, add_sel, Zin, Zlowout, PCin,
    input  c_sext, busy, done, taken, illegal
  );

  // Sequencer side
  modport slave (
    input  start, hold, ir, con,
    output Gra, Rout, CONin, PCout, Yin, Cout, add_sel, Zin, Zlowout, PCin,
    output c_sext, busy, done, taken, illegal
  );

endinterface

// File: rtl/branch_sequencer.sv
// Step generator for conditional branches (T3-T6): strobes CONin, reads back CON,
// and loads PC with PC+C only when the branch is taken.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter opcode_t OPC_BR = OPC_BR_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  branch_sequencer_if.slave  bus
);

  br_state_t state;
  br_state_t state_next;
  logic      taken_q;
  logic      illegal_q;
  logic      is_br;
  logic      accept;
  logic      reject;
  logic      unused_ir;

  // Condition bits and register fields are consumed elsewhere in the datapath.
  assign unused_ir = ^bus.ir[26:19];

  assign is_br  = (bus.ir[31:27] == OPC_BR);
  assign accept = (state == ST_IDLE) && bus.start && is_br;
  assign reject = (state == ST_IDLE) && bus.start && !is_br;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: IDLE waits for a branch start; T3..T6 advance unless held
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = ST_T3;
      ST_T3:   if (!bus.hold) state_next = ST_T4;
      ST_T4:   if (!bus.hold) state_next = ST_T5;
      ST_T5:   if (!bus.hold) state_next = ST_T6;
      ST_T6:   if (!bus.hold) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Branch decision captured on the advancing T3->T4 edge; reject pulse for bad opcodes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= reject;
      if ((state == ST_T3) && !bus.hold) begin
        taken_q <= bus.con;
      end
    end
  end

  // Moore strobe decode from the current step only
  always_comb begin
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CONin   = 1'b0;
    bus.PCout   = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.add_sel = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.done    = 1'b0;
    bus.busy    = (state != ST_IDLE);
    case (state)
      ST_T3: begin
        bus.Gra   = 1'b1;
        bus.Rout  = 1'b1;
        bus.CONin = 1'b1;
      end
      ST_T4: begin
        bus.PCout = 1'b1;
        bus.Yin   = 1'b1;
      end
      ST_T5: begin
        bus.Cout    = 1'b1;
        bus.add_sel = 1'b1;
        bus.Zin     = 1'b1;
      end
      ST_T6: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = taken_q;
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.c_sext  = sext_c(bus.ir[C_WIDTH-1:0]);
  assign bus.taken   = taken_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a step-count reference model.
module tb_branch_sequencer;

  localparam logic [4:0]  OPC_BR  = 5'b10010;
  localparam logic [31:0] IR_BRZR = 32'h9080_0004; // brzr, C=+4
  localparam logic [31:0] IR_BRNZ = 32'h908F_FFFC; // brnz, C=0x7FFFC (-4)
  localparam logic [31:0] IR_ILL  = 32'h1800_0003; // opcode 00011, C=3

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  branch_sequencer_if bus();

  branch_sequencer #(.OPC_BR(OPC_BR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // {Gra,Rout,CONin,PCout,Yin,Cout,add_sel,Zin,Zlowout,PCin}
  logic [9:0] strobes;
  assign strobes = {bus.Gra, bus.Rout, bus.CONin, bus.PCout, bus.Yin,
                    bus.Cout, bus.add_sel, bus.Zin, bus.Zlowout, bus.PCin};

  typedef struct {
    logic        start;
    logic        hold;
    logic        con;
    logic [31:0] ir;
    logic [9:0]  strobes;
    logic        busy;
    logic        done;
    logic        taken;
    logic        chk_t;
    logic        illegal;
    logic [31:0] c;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.start = 1'b0; bus.hold = 1'b0; bus.con = 1'b0; bus.ir = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference model: branch progress as a plain step number (0 = idle, 3..6 = Tn)
  int   m_step;
  logic m_taken;
  logic m_illegal;

  function automatic logic [9:0] model_strobes(input int step, input logic tk);
    case (step)
      3:       return 10'b1110000000;
      4:       return 10'b0001100000;
      5:       return 10'b0000011100;
      6:       return {8'b0, 1'b1, tk};
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_sext(input logic [31:0] ir);
    int v;
    v = int'(ir[18:0]);
    if (ir[18]) v = v - 524288;
    return 32'(v);
  endfunction

  task automatic model_edge(input logic st, input logic hd, input logic cn, input logic [31:0] ir);
    m_illegal = (m_step == 0) && st && (ir[31:27] != OPC_BR);
    if (m_step == 0) begin
      if (st && ir[31:27] == OPC_BR) m_step = 3;
    end else if (!hd) begin
      if (m_step == 3) m_taken = cn;
      m_step = (m_step == 6) ? 0 : m_step + 1;
    end
  endtask

  initial begin
    int holds;
    int cout_cnt;
    int done_at;

    bus.start = 1'b0; bus.hold = 1'b0; bus.con = 1'b0; bus.ir = '0;
    #1;
    chk("reset_strobes", 32'(strobes), 32'h0);
    chk("reset_busy",    32'(bus.busy), 32'h0);
    chk("reset_taken",   32'(bus.taken), 32'h0);
    chk("reset_illegal", 32'(bus.illegal), 32'h0);
    do_reset();

    // ---------------- table-driven vectors ----------------
    vecs[0]  = '{1'b1,1'b0,1'b1,IR_BRNZ,10'b1110000000,1'b1,1'b0,1'b0,1'b1,1'b0,32'hFFFFFFFC};
    vecs[1]  = '{1'b0,1'b0,1'b0,IR_BRNZ,10'b0001100000,1'b1,1'b0,1'b0,1'b1,1'b0,32'hFFFFFFFC};
    vecs[2]  = '{1'b1,1'b0,1'b1,IR_ILL ,10'b0000011100,1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000003};
    vecs[3]  = '{1'b0,1'b0,1'b1,IR_BRNZ,10'b0000000010,1'b1,1'b1,1'b0,1'b1,1'b0,32'hFFFFFFFC};
    vecs[4]  = '{1'b0,1'b0,1'b0,IR_BRNZ,10'b0000000000,1'b0,1'b0,1'b0,1'b1,1'b0,32'hFFFFFFFC};
    vecs[5]  = '{1'b1,1'b1,1'b0,IR_ILL ,10'b0000000000,1'b0,1'b0,1'b0,1'b1,1'b1,32'h00000003};
    vecs[6]  = '{1'b0,1'b0,1'b0,IR_ILL ,10'b0000000000,1'b0,1'b0,1'b0,1'b1,1'b0,32'h00000003};
    vecs[7]  = '{1'b1,1'b1,1'b0,IR_BRZR,10'b1110000000,1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000004};
    vecs[8]  = '{1'b0,1'b0,1'b1,IR_BRZR,10'b0001100000,1'b1,1'b0,1'b1,1'b1,1'b0,32'h00000004};
    vecs[9]  = '{1'b0,1'b0,1'b0,IR_BRZR,10'b0000011100,1'b1,1'b0,1'b1,1'b1,1'b0,32'h00000004};
    vecs[10] = '{1'b0,1'b0,1'b0,IR_BRZR,10'b0000000011,1'b1,1'b1,1'b1,1'b1,1'b0,32'h00000004};
    vecs[11] = '{1'b1,1'b0,1'b0,IR_BRZR,10'b0000000000,1'b0,1'b0,1'b1,1'b1,1'b0,32'h00000004};
    vecs[12] = '{1'b1,1'b0,1'b0,IR_BRZR,10'b1110000000,1'b1,1'b0,1'b1,1'b0,1'b0,32'h00000004};
    vecs[13] = '{1'b0,1'b0,1'b0,IR_BRZR,10'b0001100000,1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000004};
    vecs[14] = '{1'b0,1'b1,1'b1,IR_BRZR,10'b0001100000,1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000004};
    vecs[15] = '{1'b0,1'b0,1'b1,IR_BRZR,10'b0000011100,1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000004};

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      bus.start = vecs[i].start;
      bus.hold  = vecs[i].hold;
      bus.con   = vecs[i].con;
      bus.ir    = vecs[i].ir;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_strobes", i), 32'(strobes), 32'(vecs[i].strobes));
      chk($sformatf("vec%0d_busy", i),    32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i),    32'(bus.done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].illegal));
      chk($sformatf("vec%0d_c_sext", i),  bus.c_sext, vecs[i].c);
      if (vecs[i].chk_t) chk($sformatf("vec%0d_taken", i), 32'(bus.taken), 32'(vecs[i].taken));
    end

    // ---------------- hold for 3 cycles entering T5 ----------------
    do_reset();
    holds = 0; cout_cnt = 0; done_at = -1;
    @(negedge clock);
    bus.start = 1'b1; bus.ir = IR_BRZR; bus.con = 1'b1; bus.hold = 1'b0;
    @(posedge clock);
    #1;
    for (int n = 1; n <= 15; n++) begin
      if (bus.Cout) cout_cnt++;
      if (bus.done) begin
        done_at = n;
        chk("hold_taken_at_done", 32'(bus.taken), 32'h1);
        chk("hold_pcin_at_done",  32'(bus.PCin), 32'h1);
        break;
      end
      @(negedge clock);
      bus.start = 1'b0;
      bus.hold  = bus.Cout && (holds < 3);
      if (bus.hold) holds++;
      @(posedge clock);
      #1;
    end
    chk("hold_done_latency", 32'(done_at), 32'd7);
    chk("hold_cout_cycles",  32'(cout_cnt), 32'd4);
    @(negedge clock);
    bus.hold = 1'b0;
    @(posedge clock);
    #1;
    chk("hold_busy_after_done", 32'(bus.busy), 32'h0);

    // ---------------- asynchronous reset during T4 ----------------
    do_reset();
    @(negedge clock);
    bus.start = 1'b1; bus.ir = IR_BRZR; bus.con = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    chk("t4_taken_before_reset", 32'(bus.taken), 32'h1);
    chk("t4_yin_before_reset",   32'(bus.Yin), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_strobes", 32'(strobes), 32'h0);
    chk("midreset_busy",    32'(bus.busy), 32'h0);
    chk("midreset_taken",   32'(bus.taken), 32'h0);
    chk("midreset_done",    32'(bus.done), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    chk("restart_t3", 32'(strobes), 32'(10'b1110000000));

    // ---------------- randomized traffic vs. reference model ----------------
    do_reset();
    m_step = 0; m_taken = 1'b0; m_illegal = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.hold  = ($urandom_range(0, 3) == 0);
      bus.con   = 1'($urandom_range(0, 1));
      bus.ir    = $urandom;
      if ($urandom_range(0, 3) != 0) bus.ir[31:27] = OPC_BR;
      @(posedge clock);
      model_edge(bus.start, bus.hold, bus.con, bus.ir);
      #1;
      chk("rnd_strobes", 32'(strobes), 32'(model_strobes(m_step, m_taken)));
      chk("rnd_busy",    32'(bus.busy), 32'(m_step != 0));
      chk("rnd_done",    32'(bus.done), 32'(m_step == 6));
      chk("rnd_illegal", 32'(bus.illegal), 32'(m_illegal));
      chk("rnd_c_sext",  bus.c_sext, model_sext(bus.ir));
      if (m_step != 3) chk("rnd_taken", 32'(bus.taken), 32'(m_taken));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
